// File: rtl/js_input_pkg.sv
// Shared constants and types for the js_input_conditioner front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control; inputs are free-running pad levels).
package js_input_pkg;

   localparam int JS_IN_WIDTH        = 8;
   localparam int JS_SYNC_STAGES     = 2;
   localparam int JS_DEBOUNCE_CYCLES = 16;

   // Width of a counter that must reach cycles-1; never narrower than 1 bit.
   function automatic int js_cnt_width(input int cycles);
      int w;
      w = 1;
      while ((1 << w) < cycles) w++;
      return w;
   endfunction

   typedef enum logic [1:0] {
      PULSE_NONE = 2'd0,
      PULSE_RISE = 2'd1,
      PULSE_FALL = 2'd2
   } pulse_kind_e;

endpackage

// File: rtl/js_debounce_bit.sv
// One input bit: synchroniser chain, optional debounce counter, level and edge pulses.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges with JS_INPUT_DEBOUNCE_EN, else SYNC_STAGES.
// Backpressure: none; ena=0 freezes the level, clears the count and suppresses pulses.
//
// Ports: clk, rst (sync, active-high), ena, raw_in (async pad bit),
//        clean_out (accepted level), rise_pulse / fall_pulse (registered, one cycle),
//        change_nxt (pulse about to be registered; lets the parent register its OR alongside).
// Build option: JS_INPUT_DEBOUNCE_EN enables the debounce counter.
module js_debounce_bit
   import js_input_pkg::*;
#(
   parameter int SYNC_STAGES = JS_SYNC_STAGES
`ifdef JS_INPUT_DEBOUNCE_EN
  ,parameter int DEBOUNCE_CYCLES = JS_DEBOUNCE_CYCLES
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic raw_in,
   output logic clean_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic change_nxt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   stable_q;
   logic                   accept;
   pulse_kind_e            pulse_nxt;

   // Synchroniser runs regardless of ena so the pad level is always current.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef JS_INPUT_DEBOUNCE_EN
   localparam int                CNT_W   = js_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // The accepting edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
   assign accept = ena && (s != stable_q) && (cnt_q == CNT_MAX);

   // Any match, any disabled cycle, or an accept returns the count to zero,
   // so every new mismatch run starts counting from scratch.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!ena || (s == stable_q) || (cnt_q == CNT_MAX)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign accept = ena && (s != stable_q);
`endif

   always_comb begin
      pulse_nxt = PULSE_NONE;
      if (accept) begin
         pulse_nxt = s ? PULSE_RISE : PULSE_FALL;
      end
   end

   assign change_nxt = (pulse_nxt != PULSE_NONE);

   // Pulses are registered on the same edge that updates the level, so they
   // line up with the clean_out transition and can never both be high.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         if (accept) begin
            stable_q <= s;
         end
         rise_pulse <= (pulse_nxt == PULSE_RISE);
         fall_pulse <= (pulse_nxt == PULSE_FALL);
      end
   end

   assign clean_out = stable_q;

endmodule

// File: rtl/js_input_conditioner.sv
// Pad input front-end: per-bit sync + debounce, clean levels, rise/fall pulses, any_change.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges with JS_INPUT_DEBOUNCE_EN, else SYNC_STAGES.
// Backpressure: none; ena=0 holds levels, restarts debouncing and forces pulses to 0.
//
// Ports: clk, rst (sync, active-high, wins over ena), ena, raw_in[WIDTH] (ui_in pads),
//        clean_out[WIDTH], rise_pulse[WIDTH], fall_pulse[WIDTH], any_change.
// Build option: JS_INPUT_DEBOUNCE_EN enables the debounce counters; without it
//        DEBOUNCE_CYCLES only goes through the range check.
module js_input_conditioner
   import js_input_pkg::*;
#(
   parameter int WIDTH           = JS_IN_WIDTH,
   parameter int SYNC_STAGES     = JS_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = JS_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   logic [WIDTH-1:0] change_nxt;

   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
       (DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 256)) begin : g_bad_param
      $error("js_input_conditioner: SYNC_STAGES must be 2..4, DEBOUNCE_CYCLES 2..256");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      js_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES)
`ifdef JS_INPUT_DEBOUNCE_EN
        ,.DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
      ) u_bit (
         .clk        (clk),
         .rst        (rst),
         .ena        (ena),
         .raw_in     (raw_in[i]),
         .clean_out  (clean_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .change_nxt (change_nxt[i])
      );
   end

   // Built from the per-bit next-pulse terms so it is registered on the same
   // edge as the pulses themselves rather than one cycle behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |change_nxt;
      end
   end

endmodule

// File: tb/tb_js_input_conditioner.sv
// Scoreboard bench for js_input_conditioner; expected pulse events are queued
// with the edge they must appear on and matched against observed pulses.
module tb_js_input_conditioner;

`ifdef JS_INPUT_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif
   localparam int SYNC = 2;
   localparam int D    = 16;
   localparam int L    = DB ? (SYNC + D - 1) : SYNC;

   typedef struct {
      int         at;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] clean;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] raw_in;
   logic [7:0] clean_out;
   logic [7:0] rise_pulse;
   logic [7:0] fall_pulse;
   logic       any_change;

   int         edge_cnt = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   ev_t        sb[$];
   logic [7:0] exp_clean = 8'h00;

   js_input_conditioner #(
      .WIDTH           (8),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_change (any_change)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, act, exp, edge_cnt);
      end
   endtask

   task automatic push(input int at, input logic [7:0] r, input logic [7:0] f, input logic [7:0] c);
      ev_t e;
      e.at = at; e.rise = r; e.fall = f; e.clean = c;
      sb.push_back(e);
   endtask

   // Output monitor: every pulse cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      if (edge_cnt > 0) begin
         if (rise_pulse != 8'h00 || fall_pulse != 8'h00 || any_change != 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {15'd0, any_change, rise_pulse, fall_pulse}, 32'd0);
            end else begin
               ev_t e;
               e = sb.pop_front();
               chk("pulse_edge", edge_cnt, e.at);
               chk("rise_pulse", {24'd0, rise_pulse}, {24'd0, e.rise});
               chk("fall_pulse", {24'd0, fall_pulse}, {24'd0, e.fall});
               chk("clean_out", {24'd0, clean_out}, {24'd0, e.clean});
               chk("any_change", {31'd0, any_change}, {31'd0, ((e.rise | e.fall) != 8'h00)});
            end
         end else if (sb.size() > 0 && edge_cnt > sb[0].at) begin
            chk("missed_pulse", edge_cnt, sb[0].at);
            void'(sb.pop_front());
         end
      end
   end

   // Change raw_in to v and hold it; queue the resulting level change.
   task automatic apply(input logic [7:0] v);
      int n;
      @(negedge clk);
      n = edge_cnt;
      if (v != exp_clean) push(n + 1 + L, v & ~exp_clean, ~v & exp_clean, v);
      exp_clean = v;
      raw_in = v;
   endtask

   // Flip the bits in mask for len cycles, then restore.
   task automatic glitch(input logic [7:0] mask, input int len);
      int n;
      logic [7:0] v;
      @(negedge clk);
      n = edge_cnt;
      v = exp_clean ^ mask;
      if (!DB || len >= D) begin
         push(n + 1 + L, v & ~exp_clean, ~v & exp_clean, v);
         push(n + 1 + len + L, exp_clean & ~v, ~exp_clean & v, exp_clean);
      end
      raw_in = v;
      repeat (len) @(negedge clk);
      raw_in = exp_clean;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() > 0 && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (3) @(negedge clk);
      chk("idle_clean", {24'd0, clean_out}, {24'd0, exp_clean});
   endtask

   // Called at a negedge (or time 0); holds rst for two edges, checks, releases.
   task automatic do_reset();
      int n;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_clean", {24'd0, clean_out}, 32'd0);
      chk("rst_rise", {24'd0, rise_pulse}, 32'd0);
      chk("rst_fall", {24'd0, fall_pulse}, 32'd0);
      chk("rst_any", {31'd0, any_change}, 32'd0);
      sb.delete();
      rst = 1'b0;
      n = edge_cnt;
      if (raw_in != 8'h00) push(n + 1 + L, raw_in, 8'h00, raw_in);
      exp_clean = raw_in;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int m;
      rst    = 1'b1;
      ena    = 1'b1;
      raw_in = 8'hFF;

      // Input high through reset: all-ones rise after full latency.
      do_reset();
      drain();

      // Back to zero, then a clean single-bit transition both ways.
      apply(8'h00);
      drain();
      apply(8'h08);
      drain();
      apply(8'h00);
      drain();

      // Glitches around the acceptance threshold; counter restart after a short glitch.
      glitch(8'h01, 10);
      apply(8'h01);
      drain();
      apply(8'h00);
      drain();
      glitch(8'h01, 1);
      drain();
      glitch(8'h01, D - 1);
      drain();
      glitch(8'h01, D);
      drain();

      // Gate a transition in flight on bit 5.
      @(negedge clk);
      n = edge_cnt;
      raw_in = exp_clean | 8'h20;
      if (!DB) begin
         push(n + 1 + L, 8'h20, 8'h00, raw_in);
         exp_clean = raw_in;
      end
      repeat (8) @(negedge clk);
      ena = 1'b0;
      repeat (20) @(negedge clk);
      chk("gated_clean", {24'd0, clean_out}, {24'd0, exp_clean});
      ena = 1'b1;
      m = edge_cnt;
      if (DB) begin
         push(m + D, 8'h20, 8'h00, raw_in);
         exp_clean = raw_in;
      end
      drain();

      // Change on bit 6 entirely while disabled.
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      raw_in = exp_clean | 8'h40;
      repeat (10) @(negedge clk);
      chk("gated_clean_b6", {24'd0, clean_out}, {24'd0, exp_clean});
      ena = 1'b1;
      m = edge_cnt;
      push(m + (DB ? D : 1), 8'h40, 8'h00, raw_in);
      exp_clean = raw_in;
      drain();

      // Multi-bit simultaneous change.
      apply(8'h0F);
      drain();
      apply(8'hF0);
      drain();

      // Reset while a change is still being debounced.
      @(negedge clk);
      n = edge_cnt;
      raw_in = 8'hFF;
      if (!DB) push(n + 1 + L, 8'h0F, 8'h00, 8'hFF);
      repeat (5) @(negedge clk);
      do_reset();
      drain();

      chk("final_sb_empty", sb.size(), 0);
      chk("final_clean", {24'd0, clean_out}, {24'd0, exp_clean});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
